router_fsm: RTL and testbench

- Control FSM of the 1x3 router; sequences the input register, the three output FIFOs and router_sync for each packet.
- A packet is a header byte (destination in data_in[1:0]), then payload bytes, then a parity byte.
- Decodes the header and waits for the destination FIFO to drain if needed. Drives the load, write-enable and busy controls, and handles FIFO-full stalls and soft-reset aborts.

---
 rtl/router_pkg.sv | 18 +
 rtl/router_fsm.sv | 150 +++++++++++++++
 tb/tb_router_fsm.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router control path.
// State encodings are fixed binary so waveform dumps decode the same everywhere.
package router_pkg;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        FIFO_FULL_STATE    = 3'd3,
        LOAD_AFTER_FULL    = 3'd4,
        LOAD_PARITY        = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } router_state_e;

    localparam logic [1:0] ADDR_INVALID = 2'd3;

endpackage

// File: rtl/router_fsm.sv
// Packet sequencing FSM for the 1x3 router: header decode, payload/parity load,
// full-FIFO stalls and soft-reset aborts of the selected output FIFO.
//
// state              | meaning
// DECODE_ADDRESS     | idle, waiting for a header byte
// LOAD_FIRST_DATA    | writing the header into the destination FIFO
// LOAD_DATA          | streaming payload bytes
// FIFO_FULL_STATE    | stalled, destination FIFO full
// LOAD_AFTER_FULL    | writing the byte held during the stall
// LOAD_PARITY        | writing the parity byte
// CHECK_PARITY_ERROR | clearing internal parity state
// WAIT_TILL_EMPTY    | destination FIFO still draining a previous packet
module router_fsm
    import router_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              pkt_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic              fifo_full,
    input  logic              fifo_empty_0,
    input  logic              fifo_empty_1,
    input  logic              fifo_empty_2,
    input  logic              soft_reset_0,
    input  logic              soft_reset_1,
    input  logic              soft_reset_2,
    input  logic              parity_done,
    input  logic              low_pkt_valid,
    output logic              detect_add,
    output logic              lfd_state,
    output logic              ld_state,
    output logic              laf_state,
    output logic              full_state,
    output logic              write_enb_reg,
    output logic              rst_int_reg,
    output logic              busy
);

    router_state_e state_q, state_d;
    logic [1:0]    addr_q;
    logic [1:0]    hdr_addr;
    logic          hdr_valid;
    logic          hdr_empty;
    logic          sel_empty;
    logic          sel_soft_reset;

    // Only the destination bits of the byte matter here.
    logic unused_data_bits;
    assign unused_data_bits = ^data_in[DATA_W-1:2];

    assign hdr_addr  = data_in[1:0];
    assign hdr_valid = pkt_valid && (hdr_addr != ADDR_INVALID);

    always_comb begin
        hdr_empty = 1'b0;
        case (hdr_addr)
            2'd0:    hdr_empty = fifo_empty_0;
            2'd1:    hdr_empty = fifo_empty_1;
            2'd2:    hdr_empty = fifo_empty_2;
            default: hdr_empty = 1'b0;
        endcase
    end

    always_comb begin
        sel_empty      = 1'b0;
        sel_soft_reset = 1'b0;
        case (addr_q)
            2'd0: begin
                sel_empty      = fifo_empty_0;
                sel_soft_reset = soft_reset_0;
            end
            2'd1: begin
                sel_empty      = fifo_empty_1;
                sel_soft_reset = soft_reset_1;
            end
            2'd2: begin
                sel_empty      = fifo_empty_2;
                sel_soft_reset = soft_reset_2;
            end
            default: begin
                sel_empty      = 1'b0;
                sel_soft_reset = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= DECODE_ADDRESS;
            addr_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE_ADDRESS && hdr_valid) begin
                addr_q <= hdr_addr;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            DECODE_ADDRESS: begin
                if (hdr_valid) begin
                    state_d = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
            end
            WAIT_TILL_EMPTY: begin
                if (sel_empty) state_d = LOAD_FIRST_DATA;
            end
            LOAD_FIRST_DATA: state_d = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full)       state_d = FIFO_FULL_STATE;
                else if (!pkt_valid) state_d = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full) state_d = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (parity_done)        state_d = DECODE_ADDRESS;
                else if (low_pkt_valid) state_d = LOAD_PARITY;
                else                    state_d = LOAD_DATA;
            end
            LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
                state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            default: state_d = DECODE_ADDRESS;
        endcase

        // A timed-out destination FIFO abandons the packet from any active state.
        if (state_q != DECODE_ADDRESS && sel_soft_reset) begin
            state_d = DECODE_ADDRESS;
        end
    end

    always_comb begin
        detect_add    = (state_q == DECODE_ADDRESS);
        lfd_state     = (state_q == LOAD_FIRST_DATA);
        ld_state      = (state_q == LOAD_DATA);
        full_state    = (state_q == FIFO_FULL_STATE);
        laf_state     = (state_q == LOAD_AFTER_FULL);
        rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
        write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_PARITY) ||
                        (state_q == LOAD_AFTER_FULL);
        busy          = !((state_q == DECODE_ADDRESS) || (state_q == LOAD_DATA));
    end

endmodule

// File: tb/tb_router_fsm.sv
// Directed test of router_fsm: outputs are packed into one vector and compared
// against hand-derived per-state output patterns after every clock edge.
module tb_router_fsm;

    // {detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg, rst_int_reg, busy}
    localparam logic [7:0] O_DA   = 8'b1000_0000;
    localparam logic [7:0] O_LFD  = 8'b0100_0001;
    localparam logic [7:0] O_LD   = 8'b0010_0100;
    localparam logic [7:0] O_LAF  = 8'b0001_0101;
    localparam logic [7:0] O_FULL = 8'b0000_1001;
    localparam logic [7:0] O_LP   = 8'b0000_0101;
    localparam logic [7:0] O_CPE  = 8'b0000_0011;
    localparam logic [7:0] O_WTE  = 8'b0000_0001;

    logic       clock = 1'b0;
    logic       resetn;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic       parity_done, low_pkt_valid;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state;
    logic       write_enb_reg, rst_int_reg, busy;

    int errors = 0;
    int checks = 0;

    router_fsm #(.DATA_W(8)) dut (
        .clock         (clock),
        .resetn        (resetn),
        .pkt_valid     (pkt_valid),
        .data_in       (data_in),
        .fifo_full     (fifo_full),
        .fifo_empty_0  (fifo_empty_0),
        .fifo_empty_1  (fifo_empty_1),
        .fifo_empty_2  (fifo_empty_2),
        .soft_reset_0  (soft_reset_0),
        .soft_reset_1  (soft_reset_1),
        .soft_reset_2  (soft_reset_2),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .detect_add    (detect_add),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .write_enb_reg (write_enb_reg),
        .rst_int_reg   (rst_int_reg),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    task automatic check_outs(input string tag, input logic [7:0] exp);
        logic [7:0] obs;
        obs = {detect_add, lfd_state, ld_state, laf_state, full_state,
               write_enb_reg, rst_int_reg, busy};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        resetn        = 1'b0;
        pkt_valid     = 1'b0;
        data_in       = 8'h00;
        fifo_full     = 1'b0;
        fifo_empty_0  = 1'b1;
        fifo_empty_1  = 1'b1;
        fifo_empty_2  = 1'b1;
        soft_reset_0  = 1'b0;
        soft_reset_1  = 1'b0;
        soft_reset_2  = 1'b0;
        parity_done   = 1'b0;
        low_pkt_valid = 1'b0;

        #3 check_outs("reset", O_DA);
        #9 resetn = 1'b1;

        // Packet to FIFO 1, already empty
        pkt_valid = 1'b1; data_in = 8'h01;
        step(); check_outs("hdr1_lfd", O_LFD);
        data_in = 8'h55;
        step(); check_outs("p1_ld", O_LD);
        step(); check_outs("p1_ld_hold", O_LD);
        pkt_valid = 1'b0; data_in = 8'hA7;
        step(); check_outs("p1_lp", O_LP);
        step(); check_outs("p1_cpe", O_CPE);
        step(); check_outs("p1_da", O_DA);

        // Packet to FIFO 2 which is still draining
        pkt_valid = 1'b1; data_in = 8'h02; fifo_empty_2 = 1'b0;
        step(); check_outs("wte_1", O_WTE);
        data_in = 8'h11;
        step(); check_outs("wte_2", O_WTE);
        step(); check_outs("wte_3", O_WTE);
        fifo_empty_2 = 1'b1;
        step(); check_outs("wte_lfd", O_LFD);
        step(); check_outs("p2_ld", O_LD);

        // Full stall, then resume payload
        fifo_full = 1'b1;
        step(); check_outs("full_1", O_FULL);
        step(); check_outs("full_2", O_FULL);
        fifo_full = 1'b0;
        step(); check_outs("laf", O_LAF);
        step(); check_outs("laf_ld", O_LD);

        // Stall where pkt_valid fell meanwhile -> parity
        fifo_full = 1'b1;
        step(); check_outs("full_3", O_FULL);
        fifo_full = 1'b0;
        step(); check_outs("laf_2", O_LAF);
        low_pkt_valid = 1'b1;
        step(); check_outs("laf_lp", O_LP);
        low_pkt_valid = 1'b0; pkt_valid = 1'b0; fifo_full = 1'b1;
        step(); check_outs("p2_cpe", O_CPE);
        step(); check_outs("cpe_full", O_FULL);
        fifo_full = 1'b0;
        step(); check_outs("laf_3", O_LAF);
        parity_done = 1'b1;
        step(); check_outs("laf_da", O_DA);
        parity_done = 1'b0;

        // Packet to FIFO 0 aborted by its soft reset; FIFO 1 timeout ignored
        pkt_valid = 1'b1; data_in = 8'h00;
        step(); check_outs("hdr0_lfd", O_LFD);
        data_in = 8'h3C;
        step(); check_outs("p0_ld", O_LD);
        fifo_full = 1'b1;
        step(); check_outs("p0_full", O_FULL);
        soft_reset_1 = 1'b1;
        step(); check_outs("sr1_ignored", O_FULL);
        soft_reset_1 = 1'b0; soft_reset_0 = 1'b1; pkt_valid = 1'b0;
        step(); check_outs("sr0_abort", O_DA);
        soft_reset_0 = 1'b0; fifo_full = 1'b0;
        step(); check_outs("sr0_idle", O_DA);

        // Invalid destination header is dropped
        pkt_valid = 1'b1; data_in = 8'h03;
        step(); check_outs("addr3_a", O_DA);
        step(); check_outs("addr3_b", O_DA);

        // Soft reset on FIFO 2 while waiting on it
        data_in = 8'h02; fifo_empty_2 = 1'b0;
        step(); check_outs("p3_wte", O_WTE);
        soft_reset_2 = 1'b1; pkt_valid = 1'b0;
        step(); check_outs("sr2_abort", O_DA);
        soft_reset_2 = 1'b0; fifo_empty_2 = 1'b1;

        // Async reset in the middle of a payload
        pkt_valid = 1'b1; data_in = 8'h01;
        step(); check_outs("p4_lfd", O_LFD);
        data_in = 8'h99;
        step(); check_outs("p4_ld", O_LD);
        #2 resetn = 1'b0;
        #1 check_outs("async_rst", O_DA);
        #2 resetn = 1'b1;
        pkt_valid = 1'b0;
        step(); check_outs("post_rst", O_DA);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
